// File: rtl/pid_controller_sat.sv
// Velocity PID controller with a saturating integrator, anti-windup and a
// clamped unsigned output. One multiplier is shared by the P, I and D terms
// and is sequenced by a six-state FSM, so a new sample is accepted at most
// once every six cycles.
module pid_controller_sat #(
  parameter int DW   = 8,
  parameter int KW   = 4,
  parameter int IW   = 12,
  parameter int FRAC = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          sample_valid,
  input  logic [DW-1:0] target_vel,
  input  logic [DW-1:0] current_vel,
  input  logic [KW-1:0] kp,
  input  logic [KW-1:0] ki,
  input  logic [KW-1:0] kd,
  output logic [DW-1:0] vel_output,
  output logic          out_valid,
  output logic          busy,
  output logic          sat_flag
);

  localparam int EW  = DW + 1;                   // error width
  localparam int DFW = DW + 2;                   // error-difference width
  localparam int TW  = (IW > DFW) ? IW : DFW;    // multiplier term width
  localparam int PW  = KW + 1 + TW;              // product width
  localparam int SW  = KW + TW + 4;              // sum width, headroom for three products
  localparam int AW  = ((IW > EW) ? IW : EW) + 1; // integrator pre-saturation width

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_MUL_P,
    S_MUL_I,
    S_MUL_D,
    S_SUM
  } state_t;

  state_t state, state_nxt;

  // Integrator add with saturation to the signed IW-bit range
  function automatic logic signed [IW-1:0] sat_accum(input logic signed [IW-1:0] acc,
                                                     input logic signed [EW-1:0] err);
    logic signed [AW-1:0] s;
    s = AW'(acc) + AW'(err);
    if (s[AW-1:IW-1] == {(AW-IW+1){s[AW-1]}})
      sat_accum = s[IW-1:0];
    else if (s[AW-1])
      sat_accum = {1'b1, {(IW-1){1'b0}}};
    else
      sat_accum = {1'b0, {(IW-1){1'b1}}};
  endfunction

  // Output clamp to [0, 2^DW-1]; returns {clamped_high, clamped_low, value}
  function automatic logic [DW+1:0] clamp_out(input logic signed [SW-1:0] v);
    if (v[SW-1])
      clamp_out = {2'b01, {DW{1'b0}}};
    else if (|v[SW-2:DW])
      clamp_out = {2'b10, {DW{1'b1}}};
    else
      clamp_out = {2'b00, v[DW-1:0]};
  endfunction

  // Latched sample (p0), per-sample terms and running sum (p1/p2), clamped result (p3)
  logic [DW-1:0]        tgt_p0, cur_p0;
  logic [KW-1:0]        kp_p0, ki_p0, kd_p0;
  logic signed [EW-1:0] error_p1;
  logic signed [DFW-1:0] diff_p1;
  logic signed [SW-1:0] sum_p2;
  logic [DW-1:0]        res_p3;
  logic                 hi_p3, lo_p3;
  logic                 vld_p3;

  logic signed [IW-1:0] accum;
  logic signed [EW-1:0] prev_error;
  logic                 sat_hi;

  logic signed [EW-1:0]  err_c;
  logic signed [DFW-1:0] diff_c;
  logic                  hold_c;
  logic [KW-1:0]         mul_gain;
  logic signed [TW-1:0]  mul_term;
  logic signed [PW-1:0]  prod_c;
  logic signed [SW-1:0]  shifted_c;

  assign err_c     = $signed({1'b0, tgt_p0}) - $signed({1'b0, cur_p0});
  assign diff_c    = DFW'(err_c) - DFW'(prev_error);
  // Integrator freezes while the last output is clamped and the error pushes further into the clamp
  assign hold_c    = sat_flag && (sat_hi ? (!err_c[EW-1] && (|err_c)) : err_c[EW-1]);
  assign prod_c    = PW'($signed({1'b0, mul_gain})) * PW'(mul_term);
  assign shifted_c = sum_p2 >>> FRAC;
  assign busy      = (state != S_IDLE);

  // FSM state register; ce low aborts back to IDLE
  always_ff @(posedge clk) begin
    if (rst || !ce)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // FSM next-state: one state per cycle once a sample is accepted
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (sample_valid) state_nxt = S_ERR;
      S_ERR:   state_nxt = S_MUL_P;
      S_MUL_P: state_nxt = S_MUL_I;
      S_MUL_I: state_nxt = S_MUL_D;
      S_MUL_D: state_nxt = S_SUM;
      S_SUM:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shared multiplier operand select
  always_comb begin
    mul_gain = '0;
    mul_term = '0;
    case (state)
      S_MUL_P: begin mul_gain = kp_p0; mul_term = TW'(error_p1); end
      S_MUL_I: begin mul_gain = ki_p0; mul_term = TW'(accum);    end
      S_MUL_D: begin mul_gain = kd_p0; mul_term = TW'(diff_p1);  end
      default: ;
    endcase
  end

  // Datapath: latch on accept, form terms, accumulate products, clamp
  always_ff @(posedge clk) begin
    case (state)
      // p0: capture the request
      S_IDLE: begin
        if (sample_valid) begin
          tgt_p0 <= target_vel;
          cur_p0 <= current_vel;
          kp_p0  <= kp;
          ki_p0  <= ki;
          kd_p0  <= kd;
        end
      end
      // p1: error, error difference, clear the sum
      S_ERR: begin
        error_p1 <= err_c;
        diff_p1  <= diff_c;
        sum_p2   <= '0;
      end
      // p2: accumulate one product per cycle
      S_MUL_P, S_MUL_I, S_MUL_D: sum_p2 <= sum_p2 + SW'(prod_c);
      // p3: scale and clamp
      S_SUM: {hi_p3, lo_p3, res_p3} <= clamp_out(shifted_c);
      default: ;
    endcase
  end

  // Control and controller state: integrator, previous error, output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      accum      <= '0;
      prev_error <= '0;
      vld_p3     <= 1'b0;
      out_valid  <= 1'b0;
      vel_output <= '0;
      sat_flag   <= 1'b0;
      sat_hi     <= 1'b0;
    end else if (!ce) begin
      accum      <= '0;
      prev_error <= '0;
      vld_p3     <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      vld_p3    <= (state == S_SUM);
      out_valid <= vld_p3;
      if (state == S_ERR && !hold_c)
        accum <= sat_accum(accum, err_c);
      if (state == S_SUM)
        prev_error <= error_p1;
      if (vld_p3) begin
        vel_output <= res_p3;
        sat_flag   <= hi_p3 | lo_p3;
        sat_hi     <= hi_p3;
      end
    end
  end

endmodule

// File: tb/tb_pid_controller_sat.sv
// Self-checking bench for pid_controller_sat: directed vector table,
// hand-written multi-cycle sequences and randomized samples against a
// behavioural model.
module tb_pid_controller_sat;

  localparam int DW   = 8;
  localparam int KW   = 4;
  localparam int IW   = 12;
  localparam int FRAC = 0;
  localparam int OMAX = (1 << DW) - 1;
  localparam int AMAX = (1 << (IW - 1)) - 1;
  localparam int AMIN = -(1 << (IW - 1));

  logic          clk = 1'b0;
  logic          rst, ce, sample_valid;
  logic [DW-1:0] target_vel, current_vel;
  logic [KW-1:0] kp, ki, kd;
  logic [DW-1:0] vel_output;
  logic          out_valid, busy, sat_flag;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_acc, m_prev, m_sat, m_hi;

  pid_controller_sat #(.DW(DW), .KW(KW), .IW(IW), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .ce(ce), .sample_valid(sample_valid),
    .target_vel(target_vel), .current_vel(current_vel),
    .kp(kp), .ki(ki), .kd(kd),
    .vel_output(vel_output), .out_valid(out_valid), .busy(busy), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int clr;
    int tgt;
    int cur;
    int p;
    int i;
    int d;
    int eo;
    int es;
  } vec_t;

  vec_t tbl[8];

  task automatic check_eq(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic model_clear();
    m_acc  = 0;
    m_prev = 0;
  endtask

  task automatic model_step(input int t, input int c, input int p, input int i, input int d,
                            output int eo, output int es);
    int e, df, s;
    e  = t - c;
    df = e - m_prev;
    if (!(m_sat != 0 && ((m_hi != 0 && e > 0) || (m_hi == 0 && e < 0)))) begin
      m_acc = m_acc + e;
      if (m_acc > AMAX) m_acc = AMAX;
      if (m_acc < AMIN) m_acc = AMIN;
    end
    s = p * e + i * m_acc + d * df;
    s = s >>> FRAC;
    if (s > OMAX) begin eo = OMAX; es = 1; m_hi = 1; end
    else if (s < 0) begin eo = 0; es = 1; m_hi = 0; end
    else begin eo = s; es = 0; end
    m_sat  = es;
    m_prev = e;
  endtask

  task automatic set_inputs(input int t, input int c, input int p, input int i, input int d);
    target_vel  = DW'(t);
    current_vel = DW'(c);
    kp = KW'(p);
    ki = KW'(i);
    kd = KW'(d);
  endtask

  // Issue one sample from IDLE and wait (bounded) for its out_valid pulse
  task automatic do_sample(input int t, input int c, input int p, input int i, input int d,
                           output int o, output int s, output int lat);
    @(negedge clk);
    set_inputs(t, c, p, i, d);
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    o = int'(vel_output);
    s = int'(sat_flag);
  endtask

  task automatic clear_ce();
    @(negedge clk);
    ce = 1'b0;
    @(negedge clk);
    ce = 1'b1;
    model_clear();
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    m_sat = 0;
    m_hi  = 0;
  endtask

  initial begin
    int o, s, lat, cnt, eo, es, held;

    tbl[0] = '{0, 100,  90,  2, 0, 0,  20, 0};
    tbl[1] = '{1,  50,  40,  1, 1, 1,  30, 0};
    tbl[2] = '{0,  50,  40,  1, 1, 1,  30, 0};
    tbl[3] = '{1, 255,   0, 15, 1, 0, 255, 1};
    tbl[4] = '{0, 255,   0, 15, 1, 0, 255, 1};
    tbl[5] = '{0,   0, 200,  0, 1, 0,  55, 0};
    tbl[6] = '{1,  10,  60,  1, 0, 0,   0, 1};
    tbl[7] = '{0,  60,  60,  3, 0, 2, 100, 0};

    rst = 1'b1;
    ce = 1'b1;
    sample_valid = 1'b0;
    set_inputs(0, 0, 0, 0, 0);
    m_acc = 0; m_prev = 0; m_sat = 0; m_hi = 0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_vel_output", int'(vel_output), 0);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_sat_flag", int'(sat_flag), 0);
    @(negedge clk);
    rst = 1'b0;

    // directed vector table
    for (int k = 0; k < 8; k++) begin
      if (tbl[k].clr != 0) clear_ce();
      do_sample(tbl[k].tgt, tbl[k].cur, tbl[k].p, tbl[k].i, tbl[k].d, o, s, lat);
      check_eq($sformatf("vec%0d_latency", k), lat, 6);
      check_eq($sformatf("vec%0d_out", k), o, tbl[k].eo);
      check_eq($sformatf("vec%0d_sat", k), s, tbl[k].es);
    end

    // ce dropped during MUL_I: sample dropped, state cleared, output held
    @(negedge clk);
    set_inputs(200, 0, 1, 1, 1);
    sample_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sample_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    ce = 1'b0;
    @(negedge clk);
    ce = 1'b1;
    cnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) cnt++;
    end
    check_eq("abort_no_out_valid", cnt, 0);
    check_eq("abort_vel_hold", int'(vel_output), 100);
    check_eq("abort_busy", int'(busy), 0);
    do_sample(50, 40, 1, 1, 1, o, s, lat);
    check_eq("abort_next_out", o, 30);

    // integrator saturation at the positive limit, then walk it back down
    clear_ce();
    for (int n = 0; n < 9; n++) do_sample(255, 0, 0, 0, 0, o, s, lat);
    check_eq("intsat_zero_gain_out", o, 0);
    for (int n = 0; n < 8; n++) do_sample(0, 255, 0, 1, 0, o, s, lat);
    check_eq("intsat_out", o, 7);
    check_eq("intsat_sat", s, 0);

    // reset in the middle of a sample
    @(negedge clk);
    set_inputs(255, 0, 15, 0, 0);
    sample_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sample_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_vel_output", int'(vel_output), 0);
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_sat_flag", int'(sat_flag), 0);
    check_eq("midrst_out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) cnt++;
    end
    check_eq("midrst_no_out_valid", cnt, 0);

    // sample_valid while busy is ignored
    @(negedge clk);
    set_inputs(10, 60, 1, 0, 0);
    sample_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("busy_high", int'(busy), 1);
    set_inputs(255, 0, 15, 15, 15);
    repeat (3) @(negedge clk);
    sample_valid = 1'b0;
    cnt = 0;
    o = -1;
    s = -1;
    for (int n = 0; n < 14; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        cnt++;
        o = int'(vel_output);
        s = int'(sat_flag);
      end
    end
    check_eq("busy_pulse_count", cnt, 1);
    check_eq("busy_out", o, 0);
    check_eq("busy_sat", s, 1);

    // randomized samples against the model
    pulse_rst();
    for (int k = 0; k < 200; k++) begin
      int t, c, p, i, d;
      if ($urandom_range(9, 0) == 0) clear_ce();
      t = $urandom_range(OMAX, 0);
      c = $urandom_range(OMAX, 0);
      if ($urandom_range(4, 0) == 0) begin
        t = ($urandom_range(1, 0) != 0) ? OMAX : 0;
        c = OMAX - t;
      end
      p = $urandom_range((1 << KW) - 1, 0);
      i = $urandom_range((1 << KW) - 1, 0);
      d = $urandom_range((1 << KW) - 1, 0);
      model_step(t, c, p, i, d, eo, es);
      do_sample(t, c, p, i, d, o, s, lat);
      held = (lat == 6) ? 1 : 0;
      check_eq($sformatf("rnd%0d_latency", k), lat, 6);
      check_eq($sformatf("rnd%0d_out t=%0d c=%0d kp=%0d ki=%0d kd=%0d", k, t, c, p, i, d), o, eo);
      check_eq($sformatf("rnd%0d_sat", k), s, es);
      if (held == 0) break;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
